// File: rtl/lfsr_prbs_pkg.sv
// lfsr_prbs_pkg: shared LFSR single-step and popcount helpers plus the default taps.
package lfsr_prbs_pkg;

    localparam logic [30:0] TAPS_W31 = 31'h4800_0000;

    // Returns {next_state, out_bit}; bits of state at and above width are ignored.
    function automatic logic [32:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps,
                                              input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : (32'd1 << width) - 32'd1;
        return {{state[30:0], ^(state & taps & mask)} & mask, state[width-1]};
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker with SEARCH/LOCKED tracking and a
// saturating mismatched-bit counter.
module prbs_checker
    import lfsr_prbs_pkg::*;
#(
    parameter int              WIDTH       = 31,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TAPS_W31),
    parameter int              OUT_BITS    = 1,
    parameter int              LOSS_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chk_en,
    input  logic [OUT_BITS-1:0] chk_data,
    output logic                chk_locked,
    output logic                chk_err,
    output logic [15:0]         chk_err_cnt
);

    localparam logic SEARCH = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic             mode_q, mode_d;
    logic [WIDTH-1:0] chk_state_q, chk_state_d;
    logic [5:0]       fill_cnt_q, fill_cnt_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             chk_err_q, chk_err_d;
    logic [15:0]      chk_err_cnt_q, chk_err_cnt_d;

    logic [31:0]         shift;
    logic [32:0]         step;
    logic [OUT_BITS-1:0] mis;
    logic [16:0]         sum;
    logic [5:0]          fill_sum;
    logic [7:0]          loss_inc;
    logic                calc_unused;

    assign calc_unused = ^{shift, step};

    always_comb begin
        shift = 32'(chk_state_q);
        step  = '0;
        mis   = '0;
        // Predict from received history, then shift in the received bit, so one bad bit never propagates.
        for (int i = 0; i < OUT_BITS; i++) begin
            step = lfsr_step(shift, 32'(TAPS), WIDTH);
            mis[OUT_BITS-1-i] = step[1] ^ chk_data[OUT_BITS-1-i];
            shift = {shift[30:0], chk_data[OUT_BITS-1-i]};
        end
        sum           = {1'b0, chk_err_cnt_q} + 17'(popcount(8'(mis)));
        fill_sum      = fill_cnt_q + 6'(OUT_BITS);
        loss_inc      = (|mis) ? loss_cnt_q + 8'd1 : 8'd0;
        chk_state_d   = chk_en ? shift[WIDTH-1:0] : chk_state_q;
        chk_err_d     = chk_en & (mode_q == LOCKED) & (|mis);
        chk_err_cnt_d = (chk_en && mode_q == LOCKED) ? (sum[16] ? 16'hFFFF : sum[15:0]) : chk_err_cnt_q;
        mode_d        = mode_q;
        fill_cnt_d    = fill_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        if (chk_en && mode_q == SEARCH) begin
            mode_d     = (fill_sum >= 6'(WIDTH)) ? LOCKED : SEARCH;
            fill_cnt_d = (fill_sum >= 6'(WIDTH)) ? 6'd0 : fill_sum;
            loss_cnt_d = (fill_sum >= 6'(WIDTH)) ? 8'd0 : loss_cnt_q;
        end else if (chk_en) begin
            mode_d     = (loss_inc >= 8'(LOSS_THRESH)) ? SEARCH : LOCKED;
            fill_cnt_d = 6'd0;
            loss_cnt_d = loss_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= SEARCH;
            chk_state_q   <= '0;
            fill_cnt_q    <= '0;
            loss_cnt_q    <= '0;
            chk_err_q     <= 1'b0;
            chk_err_cnt_q <= '0;
        end else begin
            mode_q        <= mode_d;
            chk_state_q   <= chk_state_d;
            fill_cnt_q    <= fill_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            chk_err_q     <= chk_err_d;
            chk_err_cnt_q <= chk_err_cnt_d;
        end
    end

    assign chk_locked  = mode_q;
    assign chk_err     = chk_err_q;
    assign chk_err_cnt = chk_err_cnt_q;

endmodule

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: Fibonacci LFSR PRBS generator with seed load and zero-seed protection.
// Define LFSR_PRBS_CHECKER_EN to include the self-synchronising prbs_checker.
module lfsr_prbs_gen
    import lfsr_prbs_pkg::*;
#(
    parameter int               WIDTH       = 31,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(TAPS_W31),
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter int               OUT_BITS    = 1,
    parameter int               LOSS_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [OUT_BITS-1:0] out_data,
    output logic                seed_err,
    input  logic                chk_en,
    input  logic [OUT_BITS-1:0] chk_data,
    output logic                chk_locked,
    output logic                chk_err,
    output logic [15:0]         chk_err_cnt
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             seed_err_q, seed_err_d;
    logic [32:0]      walk;
    logic             walk_unused;

    assign walk_unused = ^walk;

    always_comb begin
        walk = {32'(state_q), 1'b0};
        for (int i = 0; i < OUT_BITS; i++) walk = lfsr_step(walk[32:1], 32'(TAPS), WIDTH);
        // A zero seed would lock the LFSR at all-zeros, so fall back to SEED instead.
        state_d    = load ? ((|seed_in) ? seed_in : SEED) : (en ? walk[WIDTH:1] : state_q);
        seed_err_d = load & ~(|seed_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEED;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign out_data = state_q[WIDTH-1 -: OUT_BITS];
    assign seed_err = seed_err_q;

`ifdef LFSR_PRBS_CHECKER_EN
    prbs_checker #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .OUT_BITS   (OUT_BITS),
        .LOSS_THRESH(LOSS_THRESH)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .chk_en     (chk_en),
        .chk_data   (chk_data),
        .chk_locked (chk_locked),
        .chk_err    (chk_err),
        .chk_err_cnt(chk_err_cnt)
    );
`else
    logic chk_unused;
    assign chk_unused  = ^{chk_en, chk_data, 8'(LOSS_THRESH)};
    assign chk_locked  = 1'b0;
    assign chk_err     = 1'b0;
    assign chk_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen: randomized bench for lfsr_prbs_gen against a bit-sequence recurrence model;
// checker scenarios run when LFSR_PRBS_CHECKER_EN is defined.
module tb_lfsr_prbs_gen;

    localparam int          W    = 31;
    localparam logic [30:0] TAPS = 31'h4800_0000;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        en1 = 1'b0, load1 = 1'b0;
    logic [30:0] seed1 = '0;
    logic        out1, serr1, lk1, ce1;
    logic [15:0] cnt1;
    logic        en8 = 1'b0, rnd_mode = 1'b0;
    logic [7:0]  out8, chk_data8, flip8 = '0, rnd8 = '0;
    logic        serr8, lk8, ce8;
    logic [15:0] cnt8;
    int          errors = 0, checks = 0, pos1 = 0, pos8 = 0;
    bit          ref_s[$];

    always #5 clk = ~clk;
    assign chk_data8 = rnd_mode ? rnd8 : (out8 ^ flip8);

    lfsr_prbs_gen u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .load(load1), .seed_in(seed1),
        .out_data(out1), .seed_err(serr1), .chk_en(1'b0), .chk_data(1'b0),
        .chk_locked(lk1), .chk_err(ce1), .chk_err_cnt(cnt1)
    );

    lfsr_prbs_gen #(.OUT_BITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .load(1'b0), .seed_in(31'h0),
        .out_data(out8), .seed_err(serr8), .chk_en(en8), .chk_data(chk_data8),
        .chk_locked(lk8), .chk_err(ce8), .chk_err_cnt(cnt8)
    );

    // Sequence model: the first W bits are the seed, oldest (MSB) first; after that
    // s[m] = XOR of s[m-1-i] over every tap bit i.
    function automatic void model_seed(input logic [30:0] sd);
        ref_s.delete();
        for (int k = W - 1; k >= 0; k--) ref_s.push_back(sd[k]);
    endfunction

    function automatic bit seqbit(input int n);
        while (ref_s.size() <= n) begin
            int m = ref_s.size();
            bit b = 1'b0;
            for (int i = 0; i < W; i++) if (TAPS[i]) b ^= ref_s[m-1-i];
            ref_s.push_back(b);
        end
        return ref_s[n];
    endfunction

    function automatic logic [7:0] word8(input int p);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7-j] = seqbit(p + j);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en1 = 1'b0; en8 = 1'b0; load1 = 1'b0; flip8 = '0; rnd_mode = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run1(input int n);
        for (int c = 0; c < n; c++) begin
            en1 = 1'($urandom_range(0, 1));
            tick();
            if (en1) pos1++;
            checks++;
            if (out1 !== seqbit(pos1)) begin
                errors++;
                $display("FAIL run1 pos %0d: got %b expected %b", pos1, out1, seqbit(pos1));
            end
        end
        en1 = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out1, out8, serr1, serr8} !== 11'h0) begin
            errors++;
            $display("FAIL reset_gen: got out1=%b out8=%h serr=%b%b expected all 0", out1, out8, serr1, serr8);
        end
        checks++;
        if ({lk1, ce1, cnt1, lk8, ce8, cnt8} !== 36'h0) begin
            errors++;
            $display("FAIL reset_chk: got lk=%b%b err=%b%b cnt=%h/%h expected all 0", lk1, lk8, ce1, ce8, cnt1, cnt8);
        end
        tick();
        rst_n = 1'b1;
        model_seed(31'h1);
        pos1 = 0;
        for (int c = 0; c < 300 && pos1 < 30; c++) begin
            en1 = 1'($urandom_range(0, 1));
            tick();
            if (en1) pos1++;
            checks++;
            if (out1 !== seqbit(pos1)) begin
                errors++;
                $display("FAIL reset_seq pos %0d: got %b expected %b", pos1, out1, seqbit(pos1));
            end
        end
        en1 = 1'b0;
        checks++;
        if (pos1 != 30 || out1 !== 1'b1) begin
            errors++;
            $display("FAIL after_30_steps: got steps=%0d out=%b expected steps=30 out=1", pos1, out1);
        end
    endtask

    task automatic test_load();
        run1(10);
        seed1 = 31'h1234_5678; load1 = 1'b1; en1 = 1'b1;
        tick();
        load1 = 1'b0; en1 = 1'b0;
        model_seed(seed1);
        pos1 = 0;
        checks++;
        if (out1 !== seqbit(0) || serr1 !== 1'b0) begin
            errors++;
            $display("FAIL load_with_en: got out=%b serr=%b expected out=%b serr=0", out1, serr1, seqbit(0));
        end
        run1(80);
        seed1 = '0; load1 = 1'b1; en1 = 1'($urandom_range(0, 1));
        tick();
        load1 = 1'b0; en1 = 1'b0;
        model_seed(31'h1);
        pos1 = 0;
        checks++;
        if (serr1 !== 1'b1 || out1 !== seqbit(0)) begin
            errors++;
            $display("FAIL zero_seed: got serr=%b out=%b expected serr=1 out=%b", serr1, out1, seqbit(0));
        end
        tick();
        checks++;
        if (serr1 !== 1'b0) begin
            errors++;
            $display("FAIL seed_err_pulse: got %b expected 0", serr1);
        end
        run1(80);
    endtask

    task automatic test_multibit();
        int n = 0;
        model_seed(31'h1);
        pos8 = 0;
        checks++;
        if (out8 !== word8(0)) begin
            errors++;
            $display("FAIL multibit_start: got %h expected %h", out8, word8(0));
        end
        for (int c = 0; c < 1000 && n < 100; c++) begin
            en8 = ($urandom_range(0, 3) != 0);
            tick();
            if (en8) begin
                pos8 += 8;
                n++;
            end
            checks++;
            if (out8 !== word8(pos8)) begin
                errors++;
                $display("FAIL multibit pos %0d: got %h expected %h", pos8, out8, word8(pos8));
            end
        end
        en8 = 1'b0;
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL multibit_count: got %0d words expected 100", n);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 200 && out8 == 8'h0; c++) begin
            en8 = 1'($urandom_range(0, 1));
            tick();
        end
        en8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out8, lk8, ce8, cnt8} !== 26'h0) begin
            errors++;
            $display("FAIL reset_mid: got out=%h lk=%b err=%b cnt=%h expected all 0", out8, lk8, ce8, cnt8);
        end
        tick();
        rst_n = 1'b1;
        model_seed(31'h1);
        pos8 = 0;
        for (int c = 0; c < 40; c++) begin
            en8 = 1'($urandom_range(0, 1));
            tick();
            if (en8) pos8 += 8;
            checks++;
            if (out8 !== word8(pos8)) begin
                errors++;
                $display("FAIL after_reset pos %0d: got %h expected %h", pos8, out8, word8(pos8));
            end
        end
        en8 = 1'b0;
    endtask

`ifdef LFSR_PRBS_CHECKER_EN
    task automatic test_lock();
        int n = 0, seen = 0;
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            en8 = 1'b1;
            tick();
            checks++;
            if (lk8 !== (w == 4)) begin
                errors++;
                $display("FAIL lock word %0d: got %b expected %b", w, lk8, (w == 4));
            end
        end
        for (int c = 0; c < 20000 && n < 10000; c++) begin
            en8 = ($urandom_range(0, 3) != 0);
            tick();
            if (en8) n++;
            if (ce8 !== 1'b0 || lk8 !== 1'b1) seen++;
        end
        en8 = 1'b0;
        checks++;
        if (n != 10000 || seen != 0 || cnt8 !== 16'h0) begin
            errors++;
            $display("FAIL clean_run: got words=%0d bad=%0d cnt=%h expected 10000/0/0000", n, seen, cnt8);
        end
    endtask

    task automatic test_err_inject();
        logic [15:0] base = cnt8;
        flip8 = 8'(1 << $urandom_range(0, 7));
        en8 = 1'b1;
        tick();
        flip8 = '0;
        checks++;
        if (ce8 !== 1'b1) begin
            errors++;
            $display("FAIL inject_pulse: got %b expected 1", ce8);
        end
        repeat (10) tick();
        en8 = 1'b0;
        checks++;
        if (cnt8 !== 16'(base + 16'd3) || lk8 !== 1'b1) begin
            errors++;
            $display("FAIL inject_count: got cnt=%h lk=%b expected cnt=%h lk=1", cnt8, lk8, 16'(base + 16'd3));
        end
    endtask

    task automatic test_loss();
        logic [15:0] base;
        flip8 = 8'hFF;
        en8 = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            tick();
            checks++;
            if (lk8 !== (w < 4) || ce8 !== 1'b1) begin
                errors++;
                $display("FAIL loss word %0d: got lk=%b err=%b expected lk=%b err=1", w, lk8, ce8, (w < 4));
            end
        end
        flip8 = '0;
        for (int w = 1; w <= 4; w++) begin
            tick();
            checks++;
            if (lk8 !== (w == 4)) begin
                errors++;
                $display("FAIL relock word %0d: got %b expected %b", w, lk8, (w == 4));
            end
        end
        base = cnt8;
        repeat (20) tick();
        en8 = 1'b0;
        checks++;
        if (cnt8 !== base || lk8 !== 1'b1) begin
            errors++;
            $display("FAIL after_relock: got cnt=%h lk=%b expected cnt=%h lk=1", cnt8, lk8, base);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] prev = '0;
        int drops = 0, sat = 0;
        do_reset();
        rnd_mode = 1'b1;
        en8 = 1'b1;
        for (int c = 0; c < 60000 && sat < 500; c++) begin
            rnd8 = 8'($urandom);
            tick();
            if (cnt8 < prev) drops++;
            prev = cnt8;
            if (cnt8 == 16'hFFFF) sat++;
        end
        en8 = 1'b0;
        rnd_mode = 1'b0;
        checks++;
        if (cnt8 !== 16'hFFFF || drops != 0) begin
            errors++;
            $display("FAIL saturate: got cnt=%h decreases=%0d expected cnt=ffff decreases=0", cnt8, drops);
        end
    endtask
`else
    task automatic test_tieoff();
        int bad = 0;
        rnd_mode = 1'b1;
        for (int c = 0; c < 50; c++) begin
            en8 = 1'($urandom_range(0, 1));
            rnd8 = 8'($urandom);
            tick();
            if ({lk8, ce8, cnt8} !== 18'h0) bad++;
        end
        en8 = 1'b0;
        rnd_mode = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tieoff: got %0d nonzero cycles expected 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_multibit();
`ifdef LFSR_PRBS_CHECKER_EN
        test_lock();
        test_err_inject();
        test_loss();
        test_reset_mid();
        test_saturate();
`else
        test_tieoff();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
